// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment driver for a signed three-digit decimal value.
// Double-buffered capture; new data becomes visible only at a frame boundary.
// Scan order is sign, hundreds, tens, units, with an all-off gap between digits.
module seg7_scan_driver #(
    parameter int unsigned DW        = 8,
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          sign,
    input  logic [DW-1:0] hundreds,
    input  logic [DW-1:0] tens,
    input  logic [DW-1:0] units,
    output logic [6:0]    seg_n,
    output logic [3:0]    an_n,
    output logic          frame_done
);

    localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] ScanLast  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYC - 1);

    localparam logic [6:0] SegOff   = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b0111111;
    localparam logic [6:0] SegErr   = 7'b0000110;
    localparam logic [3:0] AnOff    = 4'b1111;

    typedef enum logic {StScan, StBlank} state_e;

    typedef struct packed {
        logic          sign;
        logic [DW-1:0] h;
        logic [DW-1:0] t;
        logic [DW-1:0] u;
    } digits_t;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    digits_t       shadow_q, shadow_d;
    digits_t       active_q, active_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;
    logic          boundary;

    // Full-width compare so any out-of-range value, however wide, shows 'E'.
    function automatic logic [6:0] enc(input logic [DW-1:0] v);
        logic [6:0] s;
        case (v)
            DW'(0):  s = 7'b1000000;
            DW'(1):  s = 7'b1111001;
            DW'(2):  s = 7'b0100100;
            DW'(3):  s = 7'b0110000;
            DW'(4):  s = 7'b0011001;
            DW'(5):  s = 7'b0010010;
            DW'(6):  s = 7'b0000010;
            DW'(7):  s = 7'b1111000;
            DW'(8):  s = 7'b0000000;
            DW'(9):  s = 7'b0010000;
            default: s = SegErr;
        endcase
        return s;
    endfunction

    // Scan sequencing plus shadow/active buffer hand-over at the frame boundary.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CW'(1);
        boundary  = 1'b0;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        unique case (state_q)
            StScan: begin
                if (cnt_q == ScanLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d  = StScan;
                    cnt_d    = '0;
                    idx_d    = idx_q - 2'd1;
                    boundary = (idx_q == 2'd0);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        // The copy uses the old shadow, so a load on the boundary edge waits a frame.
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = '{sign: sign, h: hundreds, t: tens, u: units};
            pending_d = 1'b1;
        end
    end

    // Output decode from next state so the registered outputs line up with the FSM.
    always_comb begin
        an_d  = AnOff;
        seg_d = SegOff;
        fd_d  = boundary;
        if (state_d == StScan) begin
            unique case (idx_d)
                2'd3: begin
                    if (active_d.sign) begin
                        an_d  = 4'b0111;
                        seg_d = SegMinus;
                    end
                end
                2'd2: begin
                    if (active_d.h != '0) begin
                        an_d  = 4'b1011;
                        seg_d = enc(active_d.h);
                    end
                end
                2'd1: begin
                    if ((active_d.h != '0) || (active_d.t != '0)) begin
                        an_d  = 4'b1101;
                        seg_d = enc(active_d.t);
                    end
                end
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = enc(active_d.u);
                end
                default: begin
                    an_d  = AnOff;
                    seg_d = SegOff;
                end
            endcase
        end
    end

    // All state and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StBlank;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SegOff;
            an_q      <= AnOff;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the width of each BCD digit input.
REQ-002 The block SHALL have parameter CLK_DIV, default 50000, giving clocks per digit on-time; legal range >=1.
REQ-003 The block SHALL have parameter BLANK_CYC, default 500, giving all-anodes-off clocks between digits (anti-ghosting); legal range >=1.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 load  input  1  strobe; sign/hundreds/tens/units are captured on the rising edge where load=1.
REQ-007 sign  input  1  1 = negative.
REQ-008 hundreds, tens, units  input  DW each  decimal digit values from the two's-complement-to-decimal converter.
REQ-009 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 an_n  output  4  active-low anodes: [3] sign, [2] hundreds, [1] tens, [0] units.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Capture SHALL be double-buffered: load writes a shadow register and sets pending; a load while pending overwrites the shadow.
REQ-013 At each frame boundary with pending=1, shadow SHALL copy to active and pending SHALL clear in the same edge; a load on that same edge SHALL land in shadow and leave pending=1.
REQ-014 The FSM SHALL have states SCAN and BLANK, a 2-bit digit index idx, and a cycle counter cnt.
REQ-015 SCAN SHALL last exactly CLK_DIV cycles and then go to BLANK with the same idx.
REQ-016 BLANK SHALL last exactly BLANK_CYC cycles and then go to SCAN with idx-1 (0 wraps to 3).
REQ-017 The BLANK(idx=0)->SCAN(idx=3) transition is the frame boundary: frame_done=1 for exactly that one cycle.
REQ-018 A frame SHALL be 4*(CLK_DIV+BLANK_CYC) cycles.
REQ-019 Outputs SHALL be registered Moore decodes of state and active data, with no combinational path from any input.
REQ-020 In BLANK, an_n SHALL be 1111 and seg_n SHALL be 1111111.
REQ-021 In SCAN, the anode an_n[idx] SHALL be driven low unless that digit is blanked; a blanked digit SHALL give an_n=1111 and seg_n=1111111.
REQ-022 Sign digit: '-' (0111111) when sign=1, otherwise blanked.
REQ-023 Leading-zero blanking: hundreds SHALL be blanked when ==0; tens SHALL be blanked when hundreds==0 and tens==0; units SHALL never be blanked.
REQ-024 Digit encoding (full-width compare): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any value >9 SHALL show 'E'=0000110.

Reset
REQ-025 While rst_n=0 at an edge, the next state SHALL be: state=BLANK, idx=0, cnt=0, shadow=active=0, pending=0, an_n=1111, seg_n=1111111, frame_done=0.
REQ-026 After release, the first BLANK SHALL run BLANK_CYC cycles and exit as a frame boundary (frame_done pulses), giving SCAN idx=3.
REQ-027 Reset asserted mid-frame SHALL abort the scan and discard any pending load.

Verification (CLK_DIV=4, BLANK_CYC=1)
REQ-028 Reset scenario: rst_n=0 for 3 cycles then release -> an_n=1111, seg_n=1111111 during reset; frame_done after 1 cycle; frame shows only units '0' (an_n=1110, seg_n=1000000) for 4 cycles.
REQ-029 Negative scenario: load sign=1, h=1, t=2, u=8 -> after next frame_done: 0111/0111111, 1011/1111001, 1101/0100100, 1110/0000000, each 4 cycles separated by 1 blank cycle; period 20 cycles.
REQ-030 Leading-zero scenario: load sign=0, h=0, t=0, u=5 -> only an_n=1110 with seg_n=0010010 is displayed; then load h=0, t=0->7 -> tens shows 1111000.
REQ-031 Out-of-range scenario: load h=1, t=12, u=3 -> tens digit seg_n=0000110 ('E').
REQ-032 Mid-frame overwrite scenario: two loads (A, then B) mid-frame -> current frame is unchanged, B displays from the next frame, and A is never shown; a load coincident with the frame boundary is displayed one frame later.
REQ-033 Mid-scan reset scenario: rst_n=0 during SCAN idx=2 -> next edge an_n=1111, pending cleared, and the REQ-026 sequence restarts.
